// File: rtl/arb_types.sv
// Shared types for the I/D-cache to physical-memory line arbiter.
package arb_types;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;
    localparam int ARB_MASK_W = ARB_LINE_W / 8;

    typedef logic [ARB_LINE_W-1:0] physical_mem_word;
    typedef logic [ARB_MASK_W-1:0] physical_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        CLI_I = 1'b0,
        CLI_D = 1'b1
    } client_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/rr_pick2.sv
// Purpose: two-way round-robin picker between the I-cache and D-cache requests.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller only consumes the grant when it is ready to latch it.
module rr_pick2
    import arb_types::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_e last_grant,
    output client_e grant,
    output logic    grant_vld
);

    always_comb begin
        grant_vld = req_i | req_d;
        grant     = CLI_I;
        if (req_i && req_d) begin
            // On a tie, the client that was not served last goes first.
            grant = (last_grant == CLI_I) ? CLI_D : CLI_I;
        end else if (req_d) begin
            grant = CLI_D;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Purpose: serialise I-cache and D-cache line misses onto one physical memory port.
// Latency: request at edge 0 -> pmem strobe from cycle 1; pmem_resp at k -> client resp at k+1.
// Backpressure: one outstanding transaction; other requests wait, held by their clients.
module pmem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W,
    parameter int MASK_W = ARB_MASK_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [MASK_W-1:0] pmem_wmask,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    state_e            state_q, state_d;
    client_e           last_grant_q, last_grant_d;
    client_e           cli_q, cli_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic    d_pend;
    client_e pick;
    logic    pick_vld;
    logic    busy;
    logic    done;

    assign d_pend = d_read | d_write;

    rr_pick2 u_pick (
        .req_i      (i_read),
        .req_d      (d_pend),
        .last_grant (last_grant_q),
        .grant      (pick),
        .grant_vld  (pick_vld)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cli_d        = cli_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d      = BUSY;
                    cli_d        = pick;
                    last_grant_d = pick;
                    if (pick == CLI_I) begin
                        op_d    = OP_RD;
                        addr_d  = i_addr;
                        wmask_d = '0;
                        wdata_d = '0;
                    end else begin
                        // A simultaneous read+write from the D-cache is taken as the write.
                        op_d    = d_write ? OP_WR : OP_RD;
                        addr_d  = d_addr;
                        wmask_d = d_write ? d_wmask : '0;
                        wdata_d = d_write ? d_wdata : '0;
                    end
                end
            end
            BUSY: begin
                if (pmem_resp) begin
                    state_d = DONE;
                    if (cli_q == CLI_I) begin
                        i_rdata_d = pmem_rdata;
                    end else begin
                        d_rdata_d = pmem_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= CLI_D;
            cli_q        <= CLI_I;
            op_q         <= OP_RD;
            addr_q       <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cli_q        <= cli_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign busy       = (state_q == BUSY);
    assign done       = (state_q == DONE);
    assign pmem_read  = busy && (op_q == OP_RD);
    assign pmem_write = busy && (op_q == OP_WR);
    assign pmem_addr  = busy ? addr_q  : '0;
    assign pmem_wmask = busy ? wmask_q : '0;
    assign pmem_wdata = busy ? wdata_q : '0;

    assign i_resp  = done && (cli_q == CLI_I);
    assign d_resp  = done && (cli_q == CLI_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write))
                else $warning("pmem_arbiter: d_read and d_write both high, serviced as write");
        end
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: vector table plus reset corner sequence, memory model and response scoreboard.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         i_read;
    logic [31:0]  i_addr;
    logic         i_resp;
    logic [255:0] i_rdata;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [31:0]  d_wmask;
    logic [255:0] d_wdata;
    logic         d_resp;
    logic [255:0] d_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [31:0]  pmem_wmask;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    always #5 clk = ~clk;

    pmem_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_resp     (i_resp),
        .i_rdata    (i_rdata),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wmask    (d_wmask),
        .d_wdata    (d_wdata),
        .d_resp     (d_resp),
        .d_rdata    (d_rdata),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wmask (pmem_wmask),
        .pmem_wdata (pmem_wdata),
        .pmem_resp  (pmem_resp),
        .pmem_rdata (pmem_rdata)
    );

    // cli: 0 = I-cache, 1 = D-cache
    typedef struct {
        logic         cli;
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  wm;
        logic [255:0] wd;
        logic [255:0] rd;
    } exp_t;

    // ord: service order, bit j = client of the j-th transaction
    typedef struct {
        int          i_n;
        int          d_n;
        bit          d_rd;
        bit          d_wr;
        logic [31:0] i_a;
        logic [31:0] d_a;
        logic [31:0] wm;
        logic [7:0]  wb;
        int          lat;
        bit          drop;
        logic [3:0]  ord;
        int          ord_n;
    } vec_t;

    vec_t         vecs [11];
    exp_t         exp_txn [$];
    exp_t         exp_rsp [$];
    exp_t         cur;
    int           checks = 0;
    int           failures = 0;
    int           mem_lat = 1;
    int           mem_cnt = 0;
    bit           mem_busy = 1'b0;
    bit           resp_due = 1'b0;
    int           both_hi = 0;
    int           stab_err = 0;
    logic [255:0] i_rd_m = '0;
    logic [255:0] d_rd_m = '0;

    function automatic void chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    function automatic void chk32(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    function automatic void chk256(input string n, input logic [255:0] a, input logic [255:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (a == 32'h0000_0060) l = {8{32'hDEAD_BEEF}};
        else                    l = {8{a ^ 32'hC0DE_0000}};
        return l;
    endfunction

    function automatic void fire();
        pmem_resp  = 1'b1;
        pmem_rdata = cur.wr ? 256'h0 : line_of(cur.addr);
        mem_busy   = 1'b0;
        resp_due   = 1'b1;
    endfunction

    // One clock: sample 1 time unit after the edge, score responses, run the memory model.
    task automatic step();
        @(posedge clk);
        #1;
        if (pmem_read && pmem_write) both_hi++;
        if (resp_due) begin
            exp_t e;
            resp_due = 1'b0;
            if (exp_rsp.size() > 0) begin
                e = exp_rsp.pop_front();
                chk1("i_resp", i_resp, e.cli == 1'b0);
                chk1("d_resp", d_resp, e.cli == 1'b1);
                if (e.cli == 1'b0) begin
                    chk256("i_rdata", i_rdata, e.rd);
                    chk256("d_rdata_hold", d_rdata, d_rd_m);
                    i_rd_m = e.rd;
                end else begin
                    chk256("d_rdata", d_rdata, e.rd);
                    chk256("i_rdata_hold", i_rdata, i_rd_m);
                    d_rd_m = e.rd;
                end
            end
        end else if (i_resp || d_resp) begin
            chk1("no_spurious_resp", i_resp | d_resp, 1'b0);
        end

        if (pmem_resp) begin
            pmem_resp  = 1'b0;
            pmem_rdata = '0;
        end else if (mem_busy) begin
            if (pmem_read != !cur.wr || pmem_write != cur.wr || pmem_addr != cur.addr ||
                pmem_wmask != cur.wm) stab_err++;
            mem_cnt--;
            if (mem_cnt <= 0) fire();
        end else if (pmem_read || pmem_write) begin
            if (exp_txn.size() == 0) begin
                chk32("txn_expected", 32'(exp_txn.size()), 32'd1);
            end else begin
                cur = exp_txn.pop_front();
                chk1("start_rd", pmem_read, !cur.wr);
                chk1("start_wr", pmem_write, cur.wr);
                chk32("start_addr", pmem_addr, cur.addr);
                chk32("start_wmask", pmem_wmask, cur.wm);
                if (cur.wr) chk256("start_wdata", pmem_wdata, cur.wd);
                if (mem_lat == 0) fire();
                else begin
                    mem_cnt  = mem_lat;
                    mem_busy = 1'b1;
                end
            end
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        int   i_rem;
        int   d_rem;
        int   budget;
        bit   i_dp;
        bit   d_dp;
        v = vecs[k];
        mem_lat = v.lat;
        for (int j = 0; j < v.ord_n; j++) begin
            exp_t e;
            e.cli = v.ord[j];
            if (e.cli == 1'b0) begin
                e.wr = 1'b0; e.addr = v.i_a; e.wm = 32'h0; e.wd = '0;
            end else begin
                e.wr = v.d_wr; e.addr = v.d_a;
                e.wm = v.d_wr ? v.wm : 32'h0;
                e.wd = {32{v.wb}};
            end
            e.rd = e.wr ? 256'h0 : line_of(e.addr);
            exp_txn.push_back(e);
            exp_rsp.push_back(e);
        end
        i_read  = (v.i_n > 0);
        i_addr  = v.i_a;
        d_read  = v.d_rd && (v.d_n > 0);
        d_write = v.d_wr && (v.d_n > 0);
        d_addr  = v.d_a;
        d_wmask = v.wm;
        d_wdata = {32{v.wb}};
        i_rem = v.i_n; d_rem = v.d_n; i_dp = 1'b0; d_dp = 1'b0; budget = 0;

        step();
        chk1($sformatf("v%0d_grant_latency", k), pmem_read | pmem_write, 1'b1);
        if (v.drop) begin
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
        while ((exp_rsp.size() > 0 || i_dp || d_dp) && budget < 200) begin
            step();
            budget++;
            if (i_dp) begin i_read = 1'b0; i_dp = 1'b0; end
            if (d_dp) begin d_read = 1'b0; d_write = 1'b0; d_dp = 1'b0; end
            if (i_resp) begin i_rem--; if (i_rem <= 0) i_dp = 1'b1; end
            if (d_resp) begin d_rem--; if (d_rem <= 0) d_dp = 1'b1; end
        end
        chk32($sformatf("v%0d_rsp_drained", k), 32'(exp_rsp.size()), 32'd0);
        chk32($sformatf("v%0d_txn_drained", k), 32'(exp_txn.size()), 32'd0);
        exp_txn.delete(); exp_rsp.delete();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        //             i_n d_n d_rd  d_wr  i_a           d_a           wm            wb     lat drop  ord      n
        vecs[0]  = '{1, 1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h0,        8'h00, 1, 1'b0, 4'b0010, 2};
        vecs[1]  = '{1, 0, 1'b0, 1'b0, 32'h0000_0060, 32'h0,         32'h0,        8'h00, 2, 1'b0, 4'b0000, 1};
        vecs[2]  = '{0, 1, 1'b0, 1'b1, 32'h0,         32'h0000_0100, 32'hFFFF_FFFF, 8'hA5, 3, 1'b0, 4'b0001, 1};
        vecs[3]  = '{2, 2, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080, 32'h1234_5678, 8'h11, 1, 1'b0, 4'b1010, 4};
        vecs[4]  = '{0, 1, 1'b1, 1'b0, 32'h0,         32'h0000_0200, 32'hFFFF_0000, 8'h22, 0, 1'b0, 4'b0001, 1};
        vecs[5]  = '{1, 1, 1'b0, 1'b1, 32'h0000_0020, 32'h0000_0300, 32'h0000_FFFF, 8'h3C, 1, 1'b0, 4'b0010, 2};
        vecs[6]  = '{0, 1, 1'b1, 1'b1, 32'h0,         32'h0000_0400, 32'hF0F0_F0F0, 8'h5A, 2, 1'b0, 4'b0001, 1};
        vecs[7]  = '{1, 0, 1'b0, 1'b0, 32'h0000_0500, 32'h0,         32'h0,        8'h00, 1, 1'b0, 4'b0000, 1};
        vecs[8]  = '{1, 1, 1'b1, 1'b0, 32'h0000_0520, 32'h0000_0540, 32'h0,        8'h00, 2, 1'b0, 4'b0001, 2};
        vecs[9]  = '{0, 1, 1'b1, 1'b0, 32'h0,         32'h0000_0600, 32'h0,        8'h00, 4, 1'b1, 4'b0001, 1};
        vecs[10] = '{1, 1, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_0080, 32'h0F0F_0F0F, 8'h96, 1, 1'b0, 4'b0010, 2};

        rst_n = 1'b0;
        i_read = 1'b0; i_addr = '0;
        d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wmask = '0; d_wdata = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chk32("rst_pmem_addr", pmem_addr, 32'h0);
        chk32("rst_pmem_wmask", pmem_wmask, 32'h0);
        chk256("rst_pmem_wdata", pmem_wdata, 256'h0);
        chk1("rst_i_resp", i_resp, 1'b0);
        chk1("rst_d_resp", d_resp, 1'b0);
        chk256("rst_i_rdata", i_rdata, 256'h0);
        chk256("rst_d_rdata", d_rdata, 256'h0);
        rst_n = 1'b1;
        repeat (2) step();
        chk1("idle_no_strobe", pmem_read | pmem_write, 1'b0);

        for (int k = 0; k < 10; k++) run_vec(k);

        // Reset while a read is in flight: strobe drops at once, no response follows.
        mem_lat = 20;
        cur.cli = 1'b0; cur.wr = 1'b0; cur.addr = 32'h0000_07E0; cur.wm = 32'h0; cur.wd = '0;
        cur.rd = line_of(32'h0000_07E0);
        exp_txn.push_back(cur);
        exp_rsp.push_back(cur);
        i_read = 1'b1; i_addr = 32'h0000_07E0;
        step();
        chk1("mid_rst_strobe_up", pmem_read, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_async_drop", pmem_read, 1'b0);
        chk256("mid_rst_i_rdata_clr", i_rdata, 256'h0);
        chk256("mid_rst_d_rdata_clr", d_rdata, 256'h0);
        exp_txn.delete(); exp_rsp.delete();
        mem_busy = 1'b0; resp_due = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
        i_read = 1'b0; i_rd_m = '0; d_rd_m = '0;
        step();
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk1("post_rst_idle", pmem_read | pmem_write, 1'b0);
        run_vec(10);

        chk32("never_both_strobes", 32'(both_hi), 32'd0);
        chk32("busy_fields_stable", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
